// File: rtl/misr_pkg.sv
// Shared types and constants for the multi-lane MISR signature engine.
package misr_pkg;

  typedef enum logic [1:0] {IDLE, RUN, CMP, DONE} misr_state_e;

  // Commonly used feedback polynomials (implicit x^N term omitted), handy for poly_i.
  localparam logic [3:0]  POLY_N4  = 4'h3;
  localparam logic [7:0]  POLY_N8  = 8'h1D;
  localparam logic [15:0] POLY_N16 = 16'h1021;
  localparam logic [31:0] POLY_N32 = 32'h04C1_1DB7;
  localparam logic [63:0] POLY_N64 = 64'h1B;

endpackage

// File: rtl/misr_lane.sv
// One N-bit MISR lane: shift-left with polynomial feedback from the MSB, data XORed in.
module misr_lane #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] seed,
  input  logic         load,
  input  logic         en,
  input  logic [N-1:0] poly,
  input  logic [N-1:0] din,
  output logic [N-1:0] q
);

  logic [N-1:0] d;

  assign d = din ^ (poly & {N{q[N-1]}}) ^ {q[N-2:0], 1'b0};

  always_ff @(posedge clk) begin
    if (rst || load) begin
      q <= seed;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/multi_lane_misr_ctrl.sv
// Session controller around NUM_CH MISR lanes: counts beats, compares against golden
// signatures and reports pass/fail.
module multi_lane_misr_ctrl
  import misr_pkg::*;
#(
  parameter int           N      = 64,
  parameter int           NUM_CH = 4,
  parameter int           CNT_W  = 32,
  parameter logic [N-1:0] SEED   = N'(1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [CNT_W-1:0]    num_cycles_i,
  input  logic [N-1:0]        poly_i,
  input  logic [NUM_CH-1:0]   lane_en_i,
  input  logic                valid_i,
  input  logic [NUM_CH*N-1:0] data_i,
  input  logic [NUM_CH*N-1:0] golden_i,
  output logic                ready_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                pass_o,
  output logic [NUM_CH-1:0]   fail_mask_o,
  output logic [CNT_W-1:0]    beat_cnt_o,
  output logic [NUM_CH*N-1:0] sig_o
);

  misr_state_e state, next_state;

  logic [CNT_W-1:0]  num_cycles_q;
  logic [N-1:0]      poly_q;
  logic [NUM_CH-1:0] lane_en_q;
  logic [NUM_CH-1:0] mismatch;
  logic              start_acc;
  logic              consume;
  logic              last_beat;

  assign start_acc = (state == IDLE || state == DONE) && start_i && !abort_i;
  // An abort in the same cycle as a beat discards the beat so lanes stay as they were.
  assign consume   = valid_i && ready_o && !abort_i;
  assign last_beat = (beat_cnt_o == num_cycles_q - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (abort_i) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (start_i) next_state = (num_cycles_i == '0) ? CMP : RUN;
        RUN:        if (consume && last_beat) next_state = CMP;
        CMP:        next_state = DONE;
        default:    next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    ready_o = (state == RUN);
    busy_o  = (state == RUN) || (state == CMP);
  end

  // Session configuration, beat counter and the registered verdict.
  always_ff @(posedge clk) begin
    if (rst) begin
      num_cycles_q <= '0;
      poly_q       <= '0;
      lane_en_q    <= '0;
      beat_cnt_o   <= '0;
      done_o       <= 1'b0;
      pass_o       <= 1'b0;
      fail_mask_o  <= '0;
    end else begin
      if (abort_i) begin
        done_o      <= 1'b0;
        pass_o      <= 1'b0;
        fail_mask_o <= '0;
      end else if (start_acc) begin
        num_cycles_q <= num_cycles_i;
        poly_q       <= poly_i;
        lane_en_q    <= lane_en_i;
        beat_cnt_o   <= '0;
        done_o       <= 1'b0;
        pass_o       <= 1'b0;
        fail_mask_o  <= '0;
      end else if (state == CMP) begin
        fail_mask_o <= mismatch;
        pass_o      <= ~|mismatch;
        done_o      <= 1'b1;
      end
      if (consume) begin
        beat_cnt_o <= beat_cnt_o + CNT_W'(1);
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    misr_lane #(.N(N)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .seed (SEED),
      .load (start_acc),
      .en   (consume && lane_en_q[c]),
      .poly (poly_q),
      .din  (data_i[c*N +: N]),
      .q    (sig_o[c*N +: N])
    );

    assign mismatch[c] = lane_en_q[c] && (sig_o[c*N +: N] != golden_i[c*N +: N]);
  end

endmodule

// File: tb/tb_multi_lane_misr_ctrl.sv
// Randomised and directed bench for multi_lane_misr_ctrl with N=4, NUM_CH=2, SEED=1.
module tb_multi_lane_misr_ctrl;

  localparam int         N    = 4;
  localparam int         NCH  = 2;
  localparam int         CW   = 8;
  localparam logic [3:0] SEED = 4'h1;

  logic           clk = 1'b0;
  logic           rst, start_i, abort_i, valid_i;
  logic [CW-1:0]  num_cycles_i;
  logic [N-1:0]   poly_i;
  logic [NCH-1:0] lane_en_i;
  logic [7:0]     data_i, golden_i;
  logic           ready_o, busy_o, done_o, pass_o;
  logic [NCH-1:0] fail_mask_o;
  logic [CW-1:0]  beat_cnt_o;
  logic [7:0]     sig_o;

  int checks = 0;
  int failures = 0;

  logic [3:0] m_sig [NCH];
  logic [3:0] m_poly;
  logic [1:0] m_en;
  logic [7:0] m_golden;
  int         m_cnt;
  logic       obs_ready;
  int         obs_loop_cycles, obs_done_lat;

  multi_lane_misr_ctrl #(.N(N), .NUM_CH(NCH), .CNT_W(CW), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .num_cycles_i(num_cycles_i), .poly_i(poly_i), .lane_en_i(lane_en_i),
    .valid_i(valid_i), .data_i(data_i), .golden_i(golden_i),
    .ready_o(ready_o), .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
    .fail_mask_o(fail_mask_o), .beat_cnt_o(beat_cnt_o), .sig_o(sig_o)
  );

  always #5 clk = ~clk;

  // One lane beat: multiply by x modulo the polynomial, then add the data word.
  function automatic logic [3:0] lane_step(input logic [3:0] q, input logic [3:0] din,
                                           input logic [3:0] p);
    int v;
    v = (int'(q) * 2) % 16;
    if (int'(q) >= 8) v = v ^ int'(p);
    return 4'(v) ^ din;
  endfunction

  function automatic logic [1:0] exp_mask();
    logic [1:0] m;
    for (int c = 0; c < NCH; c++)
      m[c] = m_en[c] && (m_sig[c] != m_golden[c*4 +: 4]);
    return m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one complete session and keeps the reference model in step with it.
  task automatic run_session(input int num, input logic [3:0] poly, input logic [1:0] en,
                             input bit rand_data, input int valid_mode,
                             input bit model_golden, input logic [7:0] golden_fix);
    bit v;
    int guard;
    num_cycles_i = CW'(num); poly_i = poly; lane_en_i = en;
    start_i = 1'b1; abort_i = 1'b0; valid_i = 1'b0; golden_i = 8'($urandom);
    step();
    start_i = 1'b0;
    m_poly = poly; m_en = en; m_cnt = 0;
    for (int c = 0; c < NCH; c++) m_sig[c] = SEED;
    obs_ready = ready_o;
    poly_i = 4'($urandom); lane_en_i = 2'($urandom); num_cycles_i = CW'($urandom);
    obs_loop_cycles = 0;
    guard = 0;
    while (m_cnt < num && guard < 4000) begin
      case (valid_mode)
        0:       v = 1'b1;
        1:       v = (obs_loop_cycles % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      valid_i = v;
      data_i  = rand_data ? 8'($urandom) : 8'h00;
      start_i = 1'($urandom_range(0, 1));
      step();
      obs_loop_cycles++;
      guard++;
      if (v) begin
        for (int c = 0; c < NCH; c++)
          if (m_en[c]) m_sig[c] = lane_step(m_sig[c], data_i[c*4 +: 4], m_poly);
        m_cnt++;
      end
    end
    start_i = 1'b0;
    valid_i = 1'b1;
    data_i  = 8'($urandom);
    if (model_golden) begin
      for (int c = 0; c < NCH; c++)
        m_golden[c*4 +: 4] = m_sig[c] ^ ($urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'h0);
    end else begin
      m_golden = golden_fix;
    end
    golden_i = m_golden;
    obs_done_lat = 0;
    do begin
      step();
      obs_done_lat++;
    end while (!done_o && obs_done_lat < 10);
    valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; valid_i = 1'b0;
    num_cycles_i = '0; poly_i = '0; lane_en_i = '0; data_i = '0; golden_i = '0;
    step(); step();
    rst = 1'b0;
    checks++; if ({ready_o, busy_o, done_o, pass_o} !== 4'b0000) begin failures++;
      $display("[TB] FAIL reset_flags: got %b expected 0000", {ready_o, busy_o, done_o, pass_o}); end
    checks++; if (fail_mask_o !== 2'b00) begin failures++;
      $display("[TB] FAIL reset_mask: got %b expected 00", fail_mask_o); end
    checks++; if (beat_cnt_o !== '0) begin failures++;
      $display("[TB] FAIL reset_cnt: got %0d expected 0", beat_cnt_o); end
    checks++; if (sig_o !== 8'h11) begin failures++;
      $display("[TB] FAIL reset_sig: got %h expected 11", sig_o); end
  endtask

  task automatic test_directed_pass();
    run_session(4, 4'b0011, 2'b11, 1'b0, 0, 1'b0, 8'h33);
    checks++; if (obs_ready !== 1'b1) begin failures++;
      $display("[TB] FAIL start_to_ready: got %b expected 1", obs_ready); end
    checks++; if (sig_o !== 8'h33) begin failures++;
      $display("[TB] FAIL dir_sig: got %h expected 33", sig_o); end
    checks++; if (obs_done_lat !== 1 || done_o !== 1'b1) begin failures++;
      $display("[TB] FAIL dir_done_latency: got %0d cycles done=%b expected 1 cycle done=1", obs_done_lat, done_o); end
    checks++; if (pass_o !== 1'b1 || fail_mask_o !== 2'b00) begin failures++;
      $display("[TB] FAIL dir_pass: got pass=%b mask=%b expected pass=1 mask=00", pass_o, fail_mask_o); end
    checks++; if (beat_cnt_o !== CW'(4) || busy_o !== 1'b0) begin failures++;
      $display("[TB] FAIL dir_cnt: got cnt=%0d busy=%b expected cnt=4 busy=0", beat_cnt_o, busy_o); end
  endtask

  task automatic test_golden_fail();
    run_session(4, 4'b0011, 2'b11, 1'b0, 0, 1'b0, 8'h13);
    checks++; if (pass_o !== 1'b0 || fail_mask_o !== 2'b10) begin failures++;
      $display("[TB] FAIL golden_fail: got pass=%b mask=%b expected pass=0 mask=10", pass_o, fail_mask_o); end
  endtask

  task automatic test_lane_disable();
    run_session(4, 4'b0011, 2'b01, 1'b0, 0, 1'b0, 8'h13);
    checks++; if (sig_o !== 8'h13) begin failures++;
      $display("[TB] FAIL lane_disable_sig: got %h expected 13", sig_o); end
    checks++; if (pass_o !== 1'b1 || fail_mask_o !== 2'b00) begin failures++;
      $display("[TB] FAIL lane_disable_pass: got pass=%b mask=%b expected pass=1 mask=00", pass_o, fail_mask_o); end
    run_session(3, 4'($urandom), 2'b00, 1'b1, 2, 1'b0, 8'($urandom));
    checks++; if (pass_o !== 1'b1 || fail_mask_o !== 2'b00 || sig_o !== 8'h11) begin failures++;
      $display("[TB] FAIL no_lanes: got pass=%b mask=%b sig=%h expected pass=1 mask=00 sig=11", pass_o, fail_mask_o, sig_o); end
  endtask

  task automatic test_valid_toggle();
    run_session(4, 4'b0011, 2'b11, 1'b0, 1, 1'b0, 8'h33);
    checks++; if (obs_loop_cycles !== 7 || beat_cnt_o !== CW'(4)) begin failures++;
      $display("[TB] FAIL toggle_cnt: got %0d cycles cnt=%0d expected 7 cycles cnt=4", obs_loop_cycles, beat_cnt_o); end
    checks++; if (sig_o !== 8'h33 || pass_o !== 1'b1) begin failures++;
      $display("[TB] FAIL toggle_sig: got sig=%h pass=%b expected sig=33 pass=1", sig_o, pass_o); end
  endtask

  task automatic test_zero_cycles();
    run_session(0, 4'b0011, 2'b11, 1'b0, 0, 1'b0, 8'h11);
    checks++; if (obs_ready !== 1'b0) begin failures++;
      $display("[TB] FAIL zero_ready: got %b expected 0", obs_ready); end
    checks++; if (sig_o !== 8'h11 || pass_o !== 1'b1 || done_o !== 1'b1 || obs_done_lat !== 1) begin failures++;
      $display("[TB] FAIL zero_result: got sig=%h pass=%b done=%b lat=%0d expected sig=11 pass=1 done=1 lat=1",
               sig_o, pass_o, done_o, obs_done_lat); end
  endtask

  task automatic test_abort();
    num_cycles_i = CW'(4); poly_i = 4'b0011; lane_en_i = 2'b11; data_i = 8'h00;
    start_i = 1'b1; step(); start_i = 1'b0;
    valid_i = 1'b1; step(); step();
    valid_i = 1'b0; abort_i = 1'b1; step();
    checks++; if ({ready_o, busy_o, done_o} !== 3'b000) begin failures++;
      $display("[TB] FAIL abort_flags: got %b expected 000", {ready_o, busy_o, done_o}); end
    checks++; if (sig_o !== 8'h44 || beat_cnt_o !== CW'(2)) begin failures++;
      $display("[TB] FAIL abort_hold: got sig=%h cnt=%0d expected sig=44 cnt=2", sig_o, beat_cnt_o); end
    abort_i = 1'b0; start_i = 1'b1; step(); start_i = 1'b0;
    checks++; if (sig_o !== 8'h11 || beat_cnt_o !== '0 || ready_o !== 1'b1) begin failures++;
      $display("[TB] FAIL restart: got sig=%h cnt=%0d ready=%b expected sig=11 cnt=0 ready=1", sig_o, beat_cnt_o, ready_o); end
    abort_i = 1'b1; step();
    start_i = 1'b1; step();
    checks++; if (ready_o !== 1'b0 || busy_o !== 1'b0) begin failures++;
      $display("[TB] FAIL abort_beats_start: got ready=%b busy=%b expected 0 0", ready_o, busy_o); end
    start_i = 1'b0; abort_i = 1'b0;
    run_session(4, 4'b0011, 2'b11, 1'b0, 0, 1'b0, 8'h13);
    abort_i = 1'b1; step(); abort_i = 1'b0;
    checks++; if ({done_o, pass_o, fail_mask_o} !== 4'b0000 || sig_o !== 8'h33) begin failures++;
      $display("[TB] FAIL abort_done: got done=%b pass=%b mask=%b sig=%h expected 0 0 00 33",
               done_o, pass_o, fail_mask_o, sig_o); end
  endtask

  task automatic test_rst_mid();
    num_cycles_i = CW'(6); poly_i = 4'($urandom); lane_en_i = 2'b11;
    start_i = 1'b1; step(); start_i = 1'b0;
    valid_i = 1'b1; data_i = 8'($urandom); step(); data_i = 8'($urandom); step();
    rst = 1'b1; step(); rst = 1'b0; valid_i = 1'b0;
    checks++; if ({ready_o, busy_o, done_o, pass_o, fail_mask_o} !== 6'b0 || beat_cnt_o !== '0 || sig_o !== 8'h11) begin
      failures++;
      $display("[TB] FAIL rst_mid: got flags=%b cnt=%0d sig=%h expected flags=000000 cnt=0 sig=11",
               {ready_o, busy_o, done_o, pass_o, fail_mask_o}, beat_cnt_o, sig_o); end
  endtask

  task automatic test_random();
    logic [1:0] em;
    for (int i = 0; i < 25; i++) begin
      run_session($urandom_range(1, 12), 4'($urandom), 2'($urandom), 1'b1, 2, 1'b1, 8'h00);
      em = exp_mask();
      checks++; if (sig_o !== {m_sig[1], m_sig[0]} || beat_cnt_o !== CW'(m_cnt)) begin failures++;
        $display("[TB] FAIL rand_sig[%0d]: got sig=%h cnt=%0d expected sig=%h cnt=%0d",
                 i, sig_o, beat_cnt_o, {m_sig[1], m_sig[0]}, m_cnt); end
      checks++; if (done_o !== 1'b1 || pass_o !== ~|em || fail_mask_o !== em) begin failures++;
        $display("[TB] FAIL rand_verdict[%0d]: got done=%b pass=%b mask=%b expected done=1 pass=%b mask=%b",
                 i, done_o, pass_o, fail_mask_o, ~|em, em); end
    end
  endtask

  task automatic test_long();
    logic [1:0] em;
    run_session(255, 4'($urandom), 2'b11, 1'b1, 0, 1'b1, 8'h00);
    em = exp_mask();
    checks++; if (beat_cnt_o !== CW'(255) || done_o !== 1'b1) begin failures++;
      $display("[TB] FAIL long_cnt: got cnt=%0d done=%b expected cnt=255 done=1", beat_cnt_o, done_o); end
    checks++; if (sig_o !== {m_sig[1], m_sig[0]} || fail_mask_o !== em) begin failures++;
      $display("[TB] FAIL long_sig: got sig=%h mask=%b expected sig=%h mask=%b",
               sig_o, fail_mask_o, {m_sig[1], m_sig[0]}, em); end
  endtask

  initial begin
    test_reset();
    test_directed_pass();
    test_golden_fail();
    test_lane_disable();
    test_valid_toggle();
    test_zero_cycles();
    test_abort();
    test_rst_mid();
    test_random();
    test_long();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
